y_row_fetch: RTL and testbench
==============================

Name: y_row_fetch

Overview:
- Downstream consumer of the Y-matrix row-index stage (the 11-bit row index produced by divide-by-16 of the raw row value).
- Takes one row index per handshake, walks every column of that row in the Y-matrix SRAM, and streams complex admittance entries (real, imaginary) to the next stage under valid/ready flow control.
- A 2-entry output buffer plus credit-based read issue absorbs the 1-cycle SRAM read latency and downstream stalls without losing data.

Parameters:
ROW_W, 11, row index width
COL_W, 6, column counter width
NCOLS, 64, columns per row; must satisfy 1 <= NCOLS <= 2^COL_W
DATA_W, 16, width of each real/imag component
ADDR_W, 17, SRAM address width; must be >= ROW_W+COL_W

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
row_valid  in  1  row index offered
row_in  in  ROW_W  row index from upstream stage
row_ready  out  1  block idle; accepts row_in this cycle
sram_cs  out  1  SRAM read strobe
sram_addr  out  ADDR_W  SRAM read address
sram_rdata  in  2*DATA_W  read data {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}; valid the cycle after sram_cs=1
y_valid  out  1  output entry valid
y_ready  in  1  downstream accepts entry
y_real  out  DATA_W  real part
y_img  out  DATA_W  imaginary part
y_col  out  COL_W  column index of entry
y_last  out  1  entry is column NCOLS-1
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, col counter=0, in-flight flag=0, FIFO emptied. sram_cs=0, sram_addr=0, y_valid=0, y_real=y_img=0, y_col=0, y_last=0, busy=0. row_ready=1 (decode of IDLE).
- Reset mid-row aborts the row: no further reads, buffered entries discarded, no y_last is emitted.
- FSM IDLE: row_ready=1. If row_valid=1, latch row_in, set col=0, go to FETCH. Inputs are ignored in all other states (row_ready=0).
- FSM FETCH: issue a read when credit permits. credit = (fifo_count - pop + inflight) < 2, where pop = y_valid & y_ready in the current cycle.
  - On issue, the registered outputs show sram_cs=1 and sram_addr=row*NCOLS+col in the next cycle, then col increments.
  - After issuing col NCOLS-1, go to DRAIN.
- FSM DRAIN: no reads. Go to IDLE when the FIFO is empty and inflight=0.
- inflight is set the cycle sram_cs=1. The next cycle, sram_rdata, tagged with its col and last flag, is pushed into the FIFO and inflight clears.
- FIFO: 2 entries; push and pop in the same cycle are allowed. The credit rule guarantees it never overflows. A push with the FIFO full is an assertion failure.
- Outputs: y_valid = FIFO non-empty; y_real, y_img, y_col and y_last are taken from the FIFO head.
  - Output fields hold stable while y_valid=1 and y_ready=0.
  - The fields keep their last value when the FIFO is empty.
- Ordering: entries are emitted strictly in column order 0..NCOLS-1, exactly once each per accepted row.
- Latency with y_ready held high:
  - row accepted at edge of cycle 0; sram_cs=1 in cycle 1; first y_valid in cycle 3.
  - one entry per cycle thereafter; y_last in cycle NCOLS+2.
  - row_ready returns in cycle NCOLS+3.
- Arithmetic: address = row*NCOLS + col, zero-extended to ADDR_W, no wrap.
  - With the defaults this is {row, col}; maximum 2047*64+63 = 131071.
- Zero-wait y_ready=0 from reset: reads stop after 2 entries are buffered and 0 are in flight; no SRAM strobe while stalled.

Test Plan:
- Basic row: row_in=5, y_ready=1 -> sram_addr 320..383 on consecutive cycles; 64 entries with y_col 0..63 matching SRAM model data; y_last only at col 63; first y_valid 3 cycles after accept; row_ready back in cycle 67.
- Backpressure: y_ready toggles 1/0 randomly, plus a 20-cycle hold at 0 -> no entry lost or duplicated; outputs stable while stalled; at most 2 buffered; sram_cs=0 during the hold once credits are exhausted.
- Max address: row_in=2047 -> last sram_addr=131071; no overflow of ADDR_W.
- Busy rejection: row_valid=1 with row_in=9 asserted during a row-3 fetch -> ignored (row_ready=0); row 9 is accepted only when reoffered in IDLE.
- Mid-row reset: reset low for 1 cycle after col 10 is emitted -> all outputs immediately at reset values; FIFO empty; a new row_in=7 afterwards streams cleanly from col 0.
- Back-to-back rows: row_valid held high with rows 1 then 2 -> row 2 accepted in the first IDLE cycle after row 1's y_last drains; y_col restarts at 0.

Source files
------------

// File: rtl/y_row_fetch_if.sv
// Y-matrix row fetch bus: row handshake, SRAM read port,
// and the complex-entry output stream.
interface y_row_fetch_if #(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 6,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
);
  logic                row_valid;
  logic [ROW_W-1:0]    row_in;
  logic                row_ready;
  logic                sram_cs;
  logic [ADDR_W-1:0]   sram_addr;
  logic [2*DATA_W-1:0] sram_rdata;
  logic                y_valid;
  logic                y_ready;
  logic [DATA_W-1:0]   y_real;
  logic [DATA_W-1:0]   y_img;
  logic [COL_W-1:0]    y_col;
  logic                y_last;
  logic                busy;

  modport slave (
    input  row_valid,
    input  row_in,
    output row_ready,
    output sram_cs,
    output sram_addr,
    input  sram_rdata,
    output y_valid,
    input  y_ready,
    output y_real,
    output y_img,
    output y_col,
    output y_last,
    output busy
  );

  modport master (
    output row_valid,
    output row_in,
    input  row_ready,
    input  sram_cs,
    input  sram_addr,
    output sram_rdata,
    input  y_valid,
    output y_ready,
    input  y_real,
    input  y_img,
    input  y_col,
    input  y_last,
    input  busy
  );
endinterface

// File: rtl/y_row_fetch.sv
// Walks every column of one Y-matrix row and streams the
// complex entries through a 2-entry credit-managed buffer.
module y_row_fetch #(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 6,
  parameter int NCOLS  = 64,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic         clock,
  input  logic         reset,
  y_row_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [COL_W-1:0]  col;
    logic              last;
  } ent_t;

  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(NCOLS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             infl_q, infl_d;
  logic [COL_W-1:0] tcol_q, tcol_d;
  logic             tlast_q, tlast_d;
  logic [1:0]       cnt_q, cnt_d;
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;

  logic       pop;
  logic       push;
  logic       credit;
  logic       issue;
  logic       at_last;
  logic [2:0] occ;
  ent_t       pushed;

  // A read is only issued if its data is sure to find room
  // once it lands, counting this cycle's pop and the read
  // whose data is arriving now.
  always_comb begin
    pop     = (cnt_q != 2'd0) && bus.y_ready;
    push    = infl_q;
    occ     = {1'b0, cnt_q} - {2'b0, pop}
            + {2'b0, infl_q};
    credit  = occ < 3'd2;
    issue   = (state_q == FETCH) && credit;
    at_last = col_q == LAST_COL;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (bus.row_valid) begin
          row_d   = bus.row_in;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          if (at_last) begin
            col_d   = '0;
            state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    infl_d  = issue;
    tcol_d  = issue ? col_q : tcol_q;
    tlast_d = issue ? at_last : tlast_q;
  end

  // Head slot drives the outputs, so it keeps its last
  // value when the buffer runs empty.
  always_comb begin
    pushed.re   = bus.sram_rdata[2*DATA_W-1:DATA_W];
    pushed.im   = bus.sram_rdata[DATA_W-1:0];
    pushed.col  = tcol_q;
    pushed.last = tlast_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      (pop && cnt_q == 2'd2): head_d = tail_q;
      default: ;
    endcase
    if (push) begin
      if ((cnt_q - {1'b0, pop}) == 2'd0) begin
        head_d = pushed;
      end else begin
        tail_d = pushed;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      infl_q  <= 1'b0;
      tcol_q  <= '0;
      tlast_q <= 1'b0;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      infl_q  <= infl_d;
      tcol_q  <= tcol_d;
      tlast_q <= tlast_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset)
    !(push && cnt_q == 2'd2)
  );

  assign bus.row_ready = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.sram_cs   = issue;
  assign bus.sram_addr = ADDR_W'(row_q) * ADDR_W'(NCOLS)
                       + ADDR_W'(col_q);
  assign bus.y_valid   = cnt_q != 2'd0;
  assign bus.y_real    = head_q.re;
  assign bus.y_img     = head_q.im;
  assign bus.y_col     = head_q.col;
  assign bus.y_last    = head_q.last;

endmodule

// File: tb/tb_y_row_fetch.sv
// Scoreboard bench for y_row_fetch: random rows and random
// backpressure against a queue-based model of the row walk.
module tb_y_row_fetch;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 6;
  localparam int NCOLS  = 64;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;

  typedef struct {
    int          col;
    logic        last;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  y_row_fetch_if #(
    .ROW_W(ROW_W), .COL_W(COL_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) bus ();

  y_row_fetch #(
    .ROW_W(ROW_W), .COL_W(COL_W), .NCOLS(NCOLS),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int mode = 0;
  int reads = 0;
  int accepts = 0;
  int last_addr = 0;
  logic prev_stall = 1'b0;
  logic [38:0] prev_fields = '0;
  exp_t exp_q[$];
  int addr_q[$];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [31:0] mem_word(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  always @(posedge clock)
    if (bus.sram_cs === 1'b1)
      bus.sram_rdata <= mem_word(int'(bus.sram_addr));

  task automatic push_row(int r);
    exp_t e;
    logic [31:0] w;
    for (int c = 0; c < NCOLS; c++) begin
      w = mem_word(r * NCOLS + c);
      e.col  = c;
      e.last = (c == NCOLS - 1);
      e.re   = w[31:16];
      e.im   = w[15:0];
      exp_q.push_back(e);
      addr_q.push_back(r * NCOLS + c);
    end
  endtask

  initial begin
    bus.y_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (mode)
        0: bus.y_ready = 1'b1;
        1: bus.y_ready = 1'($urandom_range(0, 1));
        default: bus.y_ready = 1'b0;
      endcase
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", bus.y_valid, 1);
          chk("hold_fields", {bus.y_real, bus.y_img,
              bus.y_col, bus.y_last}, prev_fields);
        end
        if (bus.sram_cs) begin
          reads++;
          last_addr = int'(bus.sram_addr);
          if (addr_q.size() == 0)
            chk("unexpected_read", bus.sram_addr, 0);
          else
            chk("sram_addr", bus.sram_addr,
                addr_q.pop_front());
        end
        if (bus.y_valid && bus.y_ready) begin
          accepts++;
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", bus.y_col, 64);
          end else begin
            e = exp_q.pop_front();
            chk("y_col", bus.y_col, e.col);
            chk("y_last", bus.y_last, e.last);
            chk("y_real", bus.y_real, e.re);
            chk("y_img", bus.y_img, e.im);
          end
        end
        if (bus.sram_cs || (bus.y_valid && bus.y_ready))
          chk("outstanding_le_2",
              (reads - accepts) <= 2, 1);
        prev_stall  = bus.y_valid && !bus.y_ready;
        prev_fields = {bus.y_real, bus.y_img,
                       bus.y_col, bus.y_last};
      end
    end
  end

  task automatic chk_reset();
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_sram_cs", bus.sram_cs, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_y_real", bus.y_real, 0);
    chk("rst_y_img", bus.y_img, 0);
    chk("rst_y_col", bus.y_col, 0);
    chk("rst_y_last", bus.y_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_row_ready", bus.row_ready, 1);
  endtask

  task automatic start_row(int r, output int acc);
    acc = -1;
    @(posedge clock);
    #1;
    bus.row_valid = 1'b1;
    bus.row_in    = ROW_W'(r);
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (bus.row_ready) begin
        acc = cyc;
        push_row(r);
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    bus.row_valid = 1'b0;
  endtask

  task automatic wait_idle(int lim);
    int ok;
    ok = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clock);
      if (bus.row_ready && !bus.y_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int got;
    int hit;
    bus.row_valid = 1'b0;
    bus.row_in    = '0;
    mode = 0;
    #3;
    chk_reset();
    @(negedge clock);
    reset = 1'b1;

    // basic row with latency checks
    start_row(5, acc);
    got = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (bus.y_valid) begin got = cyc - acc; break; end
    end
    chk("first_valid_lat", got, 3);
    got = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.y_valid && bus.y_last) begin
        got = cyc - acc;
        break;
      end
    end
    chk("last_lat", got, 66);
    got = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (bus.row_ready) begin got = cyc - acc; break; end
    end
    chk("ready_lat", got, 67);

    // busy rejection
    start_row(3, acc);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #1;
    bus.row_valid = 1'b1;
    bus.row_in    = ROW_W'(9);
    repeat (5) begin
      @(negedge clock);
      chk("busy_row_ready", bus.row_ready, 0);
      chk("busy_flag", bus.busy, 1);
    end
    @(posedge clock);
    #1;
    bus.row_valid = 1'b0;
    wait_idle(200);
    start_row(9, acc);
    wait_idle(200);

    // backpressure with a 20-cycle hold
    mode = 1;
    start_row(int'($urandom_range(0, 2047)), acc);
    repeat (8) @(negedge clock);
    @(posedge clock);
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i >= 3) chk("hold_no_strobe", bus.sram_cs, 0);
      if (i == 19) chk("hold_buffered", bus.y_valid, 1);
    end
    @(posedge clock);
    mode = 1;
    wait_idle(2000);

    // max address
    start_row(2047, acc);
    wait_idle(2000);
    chk("max_addr", last_addr, 131071);

    // random rows, random backpressure
    for (int k = 0; k < 3; k++) begin
      start_row(int'($urandom_range(0, 2047)), acc);
      wait_idle(2000);
    end

    // mid-row reset
    mode = 0;
    start_row(4, acc);
    hit = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.y_valid && bus.y_ready &&
          bus.y_col == 6'd10) begin
        hit = 1;
        break;
      end
    end
    chk("col10_seen", hit, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset();
    exp_q.delete();
    addr_q.delete();
    reads = 0;
    accepts = 0;
    prev_stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    start_row(7, acc);
    wait_idle(300);

    // back-to-back rows with row_valid held
    @(posedge clock);
    #1;
    bus.row_valid = 1'b1;
    bus.row_in    = ROW_W'(1);
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (bus.row_ready) begin
        acc = cyc;
        push_row(1);
        break;
      end
    end
    chk("b2b_first_accept", acc >= 0, 1);
    @(posedge clock);
    #1;
    bus.row_in = ROW_W'(2);
    got = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.row_ready) begin
        got = cyc - acc;
        push_row(2);
        break;
      end
    end
    chk("b2b_accept_cycle", got, 67);
    @(posedge clock);
    #1;
    bus.row_valid = 1'b0;
    wait_idle(300);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
